// File: rtl/eth_mon_pkg.sv
// Shared types and constants for the GMII frame decoder: FSM states, CRC-32
// constants, preamble/SFD codes and the VLAN TPID, plus the byte-wide CRC step.
package eth_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRMBL = 3'd1,
    ST_DA    = 3'd2,
    ST_SA    = 3'd3,
    ST_TYPE  = 3'd4,
    ST_DATA  = 3'd5,
    ST_DROP  = 3'd6
  } state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  PRMBL_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [15:0] VLAN_TPID   = 16'h8100;

  // Reflected CRC-32 advanced by one byte, data consumed LSB first.
  function automatic logic [31:0] crc32_d8_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_gmii_frame_decoder_if.sv
// GMII byte stream bundle as produced by the MII/RGMII-to-GMII demultiplexer.
interface eth_gmii_frame_decoder_if;
  logic [7:0] txd;
  logic       tx_dv;
  logic       tx_er;

  modport master (output txd, tx_dv, tx_er);
  modport slave  (input  txd, tx_dv, tx_er);
endinterface

// File: rtl/eth_crc32_d8.sv
// Combinational next-state of the reflected CRC-32 register for one data byte.
module eth_crc32_d8
  import eth_mon_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // One byte of CRC advance per clock.
  always_comb begin
    crc_out = crc32_d8_step(crc_in, data);
  end

endmodule

// File: rtl/eth_gmii_frame_decoder.sv
// GMII frame decoder: strips preamble/SFD, extracts DA/SA/type, streams payload
// without FCS, checks CRC/length/framing and publishes status with a done pulse.
module eth_gmii_frame_decoder
  import eth_mon_pkg::*;
#(
  parameter int unsigned MIN_FRM_LEN = 64,
  parameter int unsigned MAX_FRM_LEN = 1518,
  parameter int unsigned JUMBO_LEN   = 9600,
  parameter int unsigned STD_PRMBL   = 7
) (
  input  logic                           tx_clk,
  input  logic                           reset,
  eth_gmii_frame_decoder_if.slave        gmii,
  input  logic                           jumbo_en,
  output logic [47:0]                    dst,
  output logic [47:0]                    src,
  output logic [15:0]                    frmtype,
  output logic [13:0]                    prmble_len,
  output logic [15:0]                    byte_cnt,
  output logic [7:0]                     payload,
  output logic                           payload_vld,
  output logic                           is_vlan,
  output logic                           crc_err,
  output logic                           prmbl_err,
  output logic                           len_err,
  output logic                           frame_err,
  output logic                           end_err,
  output logic                           frm_rcvd
);

  localparam logic [15:0] MIN_C   = 16'(MIN_FRM_LEN);
  localparam logic [15:0] MAX_C   = 16'(MAX_FRM_LEN);
  localparam logic [15:0] JUMBO_C = 16'(JUMBO_LEN);
  localparam logic [13:0] STD_C   = 14'(STD_PRMBL);

  state_e      state_q, state_d;
  logic [13:0] prm_cnt_q, prm_cnt_d;
  logic [2:0]  fld_cnt_q, fld_cnt_d;
  logic [15:0] cnt_acc_q, cnt_acc_d;
  logic [31:0] crc_q, crc_d, crc_next_s;
  logic [47:0] dst_acc_q, dst_acc_d, src_acc_q, src_acc_d;
  logic [15:0] type_acc_q, type_acc_d;
  logic        prmbl_err_acc_q, prmbl_err_acc_d;
  logic        frame_err_acc_q, frame_err_acc_d;
  logic [31:0] dly_q, dly_d;
  logic [2:0]  fill_q, fill_d;

  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] frmtype_q, frmtype_d;
  logic [13:0] prmble_len_q, prmble_len_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  payload_q, payload_d;
  logic        payload_vld_q, payload_vld_d;
  logic        is_vlan_q, is_vlan_d;
  logic        crc_err_q, crc_err_d;
  logic        prmbl_err_q, prmbl_err_d;
  logic        len_err_q, len_err_d;
  logic        frame_err_q, frame_err_d;
  logic        end_err_q, end_err_d;
  logic        frm_rcvd_q, frm_rcvd_d;

  logic        vlan_s;
  logic [15:0] limit_s;
  logic        len_bad_s;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii.txd),
    .crc_out (crc_next_s)
  );

  // Next-state, field accumulation, payload delay line and end-of-frame status latch.
  always_comb begin
    state_d         = state_q;
    prm_cnt_d       = prm_cnt_q;
    fld_cnt_d       = fld_cnt_q;
    cnt_acc_d       = cnt_acc_q;
    crc_d           = crc_q;
    dst_acc_d       = dst_acc_q;
    src_acc_d       = src_acc_q;
    type_acc_d      = type_acc_q;
    prmbl_err_acc_d = prmbl_err_acc_q;
    frame_err_acc_d = frame_err_acc_q;
    dly_d           = dly_q;
    fill_d          = fill_q;
    dst_d           = dst_q;
    src_d           = src_q;
    frmtype_d       = frmtype_q;
    prmble_len_d    = prmble_len_q;
    byte_cnt_d      = byte_cnt_q;
    payload_d       = payload_q;
    payload_vld_d   = 1'b0;
    is_vlan_d       = is_vlan_q;
    crc_err_d       = crc_err_q;
    prmbl_err_d     = prmbl_err_q;
    len_err_d       = len_err_q;
    frame_err_d     = frame_err_q;
    end_err_d       = end_err_q;
    frm_rcvd_d      = 1'b0;

    vlan_s    = (type_acc_q == VLAN_TPID);
    limit_s   = (jumbo_en ? JUMBO_C : MAX_C) + (vlan_s ? 16'd4 : 16'd0);
    len_bad_s = (cnt_acc_q < MIN_C) || (cnt_acc_q > limit_s);

    if ((state_q != ST_IDLE) && !gmii.tx_dv) begin
      // dv just fell: publish everything accumulated for this frame
      state_d      = ST_IDLE;
      frm_rcvd_d   = 1'b1;
      dst_d        = dst_acc_q;
      src_d        = src_acc_q;
      frmtype_d    = type_acc_q;
      prmble_len_d = prm_cnt_q;
      byte_cnt_d   = cnt_acc_q;
      is_vlan_d    = vlan_s;
      crc_err_d    = (crc_q != CRC_RESIDUE);
      prmbl_err_d  = prmbl_err_acc_q;
      len_err_d    = len_bad_s;
      frame_err_d  = frame_err_acc_q;
      end_err_d    = state_q inside {ST_PRMBL, ST_DA, ST_SA, ST_TYPE};
    end else if (gmii.tx_dv) begin
      frame_err_acc_d = frame_err_acc_q | gmii.tx_er;
      if (state_q inside {ST_DA, ST_SA, ST_TYPE, ST_DATA}) begin
        crc_d     = crc_next_s;
        cnt_acc_d = (cnt_acc_q == 16'hFFFF) ? cnt_acc_q : cnt_acc_q + 16'd1;
      end else begin
        crc_d     = crc_q;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_acc_d       = 16'd0;
          crc_d           = CRC_INIT;
          dst_acc_d       = 48'd0;
          src_acc_d       = 48'd0;
          type_acc_d      = 16'd0;
          fld_cnt_d       = 3'd0;
          fill_d          = 3'd0;
          frame_err_acc_d = gmii.tx_er;
          if (gmii.txd == PRMBL_BYTE) begin
            state_d         = ST_PRMBL;
            prm_cnt_d       = 14'd1;
            prmbl_err_acc_d = 1'b0;
          end else if (gmii.txd == SFD_BYTE) begin
            state_d         = ST_DA;
            prm_cnt_d       = 14'd0;
            prmbl_err_acc_d = 1'b1;
          end else begin
            state_d         = ST_DROP;
            prm_cnt_d       = 14'd0;
            prmbl_err_acc_d = 1'b1;
          end
        end
        ST_PRMBL: begin
          if (gmii.txd == PRMBL_BYTE) begin
            prm_cnt_d = (prm_cnt_q == 14'h3FFF) ? prm_cnt_q : prm_cnt_q + 14'd1;
          end else if (gmii.txd == SFD_BYTE) begin
            state_d         = ST_DA;
            prmbl_err_acc_d = (prm_cnt_q != STD_C);
          end else begin
            state_d         = ST_DROP;
            prmbl_err_acc_d = 1'b1;
          end
        end
        ST_DA: begin
          dst_acc_d = {dst_acc_q[39:0], gmii.txd};
          if (fld_cnt_q == 3'd5) begin
            state_d   = ST_SA;
            fld_cnt_d = 3'd0;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
        ST_SA: begin
          src_acc_d = {src_acc_q[39:0], gmii.txd};
          if (fld_cnt_q == 3'd5) begin
            state_d   = ST_TYPE;
            fld_cnt_d = 3'd0;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
        ST_TYPE: begin
          type_acc_d = {type_acc_q[7:0], gmii.txd};
          if (fld_cnt_q == 3'd1) begin
            state_d   = ST_DATA;
            fld_cnt_d = 3'd0;
            fill_d    = 3'd0;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
        ST_DATA: begin
          // Four bytes in flight hold back the FCS; only older bytes leave.
          dly_d = {dly_q[23:0], gmii.txd};
          if (fill_q == 3'd4) begin
            payload_d     = dly_q[31:24];
            payload_vld_d = 1'b1;
          end else begin
            fill_d        = fill_q + 3'd1;
          end
        end
        ST_DROP: begin
          state_d = ST_DROP;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      prm_cnt_q       <= 14'd0;
      fld_cnt_q       <= 3'd0;
      cnt_acc_q       <= 16'd0;
      crc_q           <= CRC_INIT;
      dst_acc_q       <= 48'd0;
      src_acc_q       <= 48'd0;
      type_acc_q      <= 16'd0;
      prmbl_err_acc_q <= 1'b0;
      frame_err_acc_q <= 1'b0;
      dly_q           <= 32'd0;
      fill_q          <= 3'd0;
      dst_q           <= 48'd0;
      src_q           <= 48'd0;
      frmtype_q       <= 16'd0;
      prmble_len_q    <= 14'd0;
      byte_cnt_q      <= 16'd0;
      payload_q       <= 8'd0;
      payload_vld_q   <= 1'b0;
      is_vlan_q       <= 1'b0;
      crc_err_q       <= 1'b0;
      prmbl_err_q     <= 1'b0;
      len_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      end_err_q       <= 1'b0;
      frm_rcvd_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      prm_cnt_q       <= prm_cnt_d;
      fld_cnt_q       <= fld_cnt_d;
      cnt_acc_q       <= cnt_acc_d;
      crc_q           <= crc_d;
      dst_acc_q       <= dst_acc_d;
      src_acc_q       <= src_acc_d;
      type_acc_q      <= type_acc_d;
      prmbl_err_acc_q <= prmbl_err_acc_d;
      frame_err_acc_q <= frame_err_acc_d;
      dly_q           <= dly_d;
      fill_q          <= fill_d;
      dst_q           <= dst_d;
      src_q           <= src_d;
      frmtype_q       <= frmtype_d;
      prmble_len_q    <= prmble_len_d;
      byte_cnt_q      <= byte_cnt_d;
      payload_q       <= payload_d;
      payload_vld_q   <= payload_vld_d;
      is_vlan_q       <= is_vlan_d;
      crc_err_q       <= crc_err_d;
      prmbl_err_q     <= prmbl_err_d;
      len_err_q       <= len_err_d;
      frame_err_q     <= frame_err_d;
      end_err_q       <= end_err_d;
      frm_rcvd_q      <= frm_rcvd_d;
    end
  end

  assign dst         = dst_q;
  assign src         = src_q;
  assign frmtype     = frmtype_q;
  assign prmble_len  = prmble_len_q;
  assign byte_cnt    = byte_cnt_q;
  assign payload     = payload_q;
  assign payload_vld = payload_vld_q;
  assign is_vlan     = is_vlan_q;
  assign crc_err     = crc_err_q;
  assign prmbl_err   = prmbl_err_q;
  assign len_err     = len_err_q;
  assign frame_err   = frame_err_q;
  assign end_err     = end_err_q;
  assign frm_rcvd    = frm_rcvd_q;

endmodule

// File: tb/tb_eth_gmii_frame_decoder.sv
// Directed bench for eth_gmii_frame_decoder: builds frames with a bit-serial
// reference FCS and checks fields, status flags and the payload stream.
module tb_eth_gmii_frame_decoder;

  logic        tx_clk = 1'b0;
  logic        reset;
  logic        jumbo_en;
  logic [47:0] dst, src;
  logic [15:0] frmtype, byte_cnt;
  logic [13:0] prmble_len;
  logic [7:0]  payload;
  logic        payload_vld, is_vlan, crc_err, prmbl_err, len_err, frame_err, end_err, frm_rcvd;

  int vecs  = 0;
  int fails = 0;

  eth_gmii_frame_decoder_if gmii_if ();

  eth_gmii_frame_decoder dut (
    .tx_clk      (tx_clk),
    .reset       (reset),
    .gmii        (gmii_if),
    .jumbo_en    (jumbo_en),
    .dst         (dst),
    .src         (src),
    .frmtype     (frmtype),
    .prmble_len  (prmble_len),
    .byte_cnt    (byte_cnt),
    .payload     (payload),
    .payload_vld (payload_vld),
    .is_vlan     (is_vlan),
    .crc_err     (crc_err),
    .prmbl_err   (prmbl_err),
    .len_err     (len_err),
    .frame_err   (frame_err),
    .end_err     (end_err),
    .frm_rcvd    (frm_rcvd)
  );

  always #5 tx_clk = ~tx_clk;

  int         rcvd_cnt;
  logic [7:0] pay_q[$];
  logic [7:0] body[$];

  always @(negedge tx_clk) begin
    if (payload_vld === 1'b1) pay_q.push_back(payload);
    if (frm_rcvd === 1'b1) rcvd_cnt++;
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(negedge tx_clk);
    gmii_if.txd   = d;
    gmii_if.tx_dv = v;
    gmii_if.tx_er = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  // DA 01..06, SA 0A..0F, type, nd bytes counting from 0, then FCS LSB first.
  task automatic build(input logic [15:0] ftype, input int nd);
    logic [31:0] c;
    logic [31:0] fcs;
    logic        fb;
    body.delete();
    for (int i = 0; i < 6; i++) body.push_back(8'(i + 1));
    for (int i = 0; i < 6; i++) body.push_back(8'(i + 10));
    body.push_back(ftype[15:8]);
    body.push_back(ftype[7:0]);
    for (int i = 0; i < nd; i++) body.push_back(8'(i));
    c = 32'hFFFFFFFF;
    foreach (body[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body[k][b];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    fcs = ~c;
    body.push_back(fcs[7:0]);
    body.push_back(fcs[15:8]);
    body.push_back(fcs[23:16]);
    body.push_back(fcs[31:24]);
  endtask

  task automatic send(input int npre, input int er_idx, input int stop_at, input bit rst_abort);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < body.size(); i++) begin
      if (i == stop_at) break;
      drive(body[i], 1'b1, 1'(i == er_idx));
    end
    if (rst_abort) begin
      @(negedge tx_clk);
      reset = 1'b1;
      gmii_if.tx_dv = 1'b0;
      gmii_if.tx_er = 1'b0;
      @(negedge tx_clk);
      reset = 1'b0;
    end else begin
      drive(8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_mon();
    rcvd_cnt = 0;
    pay_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    jumbo_en = 1'b0;
    gmii_if.txd = 8'h00;
    gmii_if.tx_dv = 1'b0;
    gmii_if.tx_er = 1'b0;
    idle(3);
    reset = 1'b0;
    clear_mon();
    idle(2);
    if ({dst, src, frmtype} !== 112'd0) begin $display("FAIL rst_fields got %h want 0", {dst, src, frmtype}); fails++; end vecs++;
    if ({prmble_len, byte_cnt, payload} !== 38'd0) begin $display("FAIL rst_counts got %h want 0", {prmble_len, byte_cnt, payload}); fails++; end vecs++;
    if ({payload_vld, is_vlan, crc_err, prmbl_err, len_err, frame_err, end_err, frm_rcvd} !== 8'd0) begin
      $display("FAIL rst_flags got %b want 00000000", {payload_vld, is_vlan, crc_err, prmbl_err, len_err, frame_err, end_err, frm_rcvd}); fails++; end vecs++;
  endtask

  task automatic test_good_frame();
    int bad;
    build(16'h0800, 46);
    clear_mon();
    send(7, -1, -1, 1'b0);
    idle(3);
    bad = 0;
    for (int i = 0; i < pay_q.size(); i++) if (pay_q[i] !== 8'(i)) bad++;
    if (rcvd_cnt !== 1) begin $display("FAIL good_rcvd got %0d want 1", rcvd_cnt); fails++; end vecs++;
    if (dst !== 48'h010203040506) begin $display("FAIL good_dst got %h want 010203040506", dst); fails++; end vecs++;
    if (src !== 48'h0A0B0C0D0E0F) begin $display("FAIL good_src got %h want 0a0b0c0d0e0f", src); fails++; end vecs++;
    if (frmtype !== 16'h0800) begin $display("FAIL good_type got %h want 0800", frmtype); fails++; end vecs++;
    if (prmble_len !== 14'd7) begin $display("FAIL good_prmble_len got %0d want 7", prmble_len); fails++; end vecs++;
    if (byte_cnt !== 16'd64) begin $display("FAIL good_byte_cnt got %0d want 64", byte_cnt); fails++; end vecs++;
    if ({is_vlan, crc_err, prmbl_err, len_err, frame_err, end_err} !== 6'd0) begin
      $display("FAIL good_flags got %b want 000000", {is_vlan, crc_err, prmbl_err, len_err, frame_err, end_err}); fails++; end vecs++;
    if (pay_q.size() !== 46) begin $display("FAIL good_pay_len got %0d want 46", pay_q.size()); fails++; end vecs++;
    if (bad !== 0) begin $display("FAIL good_pay_data got %0d bad bytes want 0", bad); fails++; end vecs++;
  endtask

  task automatic test_crc_err();
    build(16'h0800, 46);
    body[body.size() - 1] = body[body.size() - 1] ^ 8'h01;
    clear_mon();
    send(7, -1, -1, 1'b0);
    idle(3);
    if ({crc_err, prmbl_err, len_err, frame_err, end_err} !== 5'b10000) begin
      $display("FAIL crc_flags got %b want 10000", {crc_err, prmbl_err, len_err, frame_err, end_err}); fails++; end vecs++;
    if (pay_q.size() !== 46) begin $display("FAIL crc_pay_len got %0d want 46", pay_q.size()); fails++; end vecs++;
  endtask

  task automatic test_short_preamble();
    build(16'h0800, 46);
    clear_mon();
    send(5, -1, -1, 1'b0);
    idle(3);
    if ({crc_err, prmbl_err, len_err, end_err} !== 4'b0100) begin
      $display("FAIL prm5_flags got %b want 0100", {crc_err, prmbl_err, len_err, end_err}); fails++; end vecs++;
    if (prmble_len !== 14'd5) begin $display("FAIL prm5_len got %0d want 5", prmble_len); fails++; end vecs++;
    if (dst !== 48'h010203040506) begin $display("FAIL prm5_dst got %h want 010203040506", dst); fails++; end vecs++;
  endtask

  task automatic test_sfd_only_min_len();
    build(16'h0800, 45);
    clear_mon();
    send(0, -1, -1, 1'b0);
    idle(3);
    if (byte_cnt !== 16'd63) begin $display("FAIL sfd63_byte_cnt got %0d want 63", byte_cnt); fails++; end vecs++;
    if ({crc_err, prmbl_err, len_err, end_err} !== 4'b0110) begin
      $display("FAIL sfd63_flags got %b want 0110", {crc_err, prmbl_err, len_err, end_err}); fails++; end vecs++;
    if (prmble_len !== 14'd0) begin $display("FAIL sfd63_prm_len got %0d want 0", prmble_len); fails++; end vecs++;
    if (pay_q.size() !== 45) begin $display("FAIL sfd63_pay_len got %0d want 45", pay_q.size()); fails++; end vecs++;
  endtask

  task automatic test_truncated();
    build(16'h0800, 46);
    clear_mon();
    send(7, -1, 10, 1'b0);
    idle(3);
    if (rcvd_cnt !== 1) begin $display("FAIL trunc_rcvd got %0d want 1", rcvd_cnt); fails++; end vecs++;
    if (byte_cnt !== 16'd10) begin $display("FAIL trunc_byte_cnt got %0d want 10", byte_cnt); fails++; end vecs++;
    if ({crc_err, prmbl_err, len_err, frame_err, end_err} !== 5'b10101) begin
      $display("FAIL trunc_flags got %b want 10101", {crc_err, prmbl_err, len_err, frame_err, end_err}); fails++; end vecs++;
    if (pay_q.size() !== 0) begin $display("FAIL trunc_pay_len got %0d want 0", pay_q.size()); fails++; end vecs++;
  endtask

  task automatic test_tx_er();
    build(16'h0800, 46);
    clear_mon();
    send(7, 20, -1, 1'b0);
    idle(3);
    if ({crc_err, prmbl_err, len_err, frame_err, end_err} !== 5'b00010) begin
      $display("FAIL txer_flags got %b want 00010", {crc_err, prmbl_err, len_err, frame_err, end_err}); fails++; end vecs++;
  endtask

  task automatic test_lengths();
    int bad;
    build(16'h0800, 1582);
    jumbo_en = 1'b0;
    clear_mon();
    send(7, -1, -1, 1'b0);
    idle(3);
    bad = 0;
    for (int i = 0; i < pay_q.size(); i++) if (pay_q[i] !== 8'(i)) bad++;
    if (byte_cnt !== 16'd1600) begin $display("FAIL len1600_byte_cnt got %0d want 1600", byte_cnt); fails++; end vecs++;
    if ({crc_err, len_err} !== 2'b01) begin $display("FAIL len1600_std got %b want 01", {crc_err, len_err}); fails++; end vecs++;
    if (pay_q.size() !== 1582 || bad !== 0) begin $display("FAIL len1600_pay got %0d/%0d bad want 1582/0", pay_q.size(), bad); fails++; end vecs++;
    jumbo_en = 1'b1;
    clear_mon();
    send(7, -1, -1, 1'b0);
    idle(3);
    if ({crc_err, len_err} !== 2'b00) begin $display("FAIL len1600_jumbo got %b want 00", {crc_err, len_err}); fails++; end vecs++;
    jumbo_en = 1'b0;
    build(16'h8100, 1504);
    clear_mon();
    send(7, -1, -1, 1'b0);
    idle(3);
    if (byte_cnt !== 16'd1522) begin $display("FAIL vlan_byte_cnt got %0d want 1522", byte_cnt); fails++; end vecs++;
    if ({is_vlan, crc_err, len_err} !== 3'b100) begin $display("FAIL vlan_flags got %b want 100", {is_vlan, crc_err, len_err}); fails++; end vecs++;
  endtask

  task automatic test_back_to_back();
    build(16'h0800, 46);
    clear_mon();
    send(7, -1, -1, 1'b0);
    send(7, -1, -1, 1'b0);
    idle(3);
    if (rcvd_cnt !== 2) begin $display("FAIL b2b_rcvd got %0d want 2", rcvd_cnt); fails++; end vecs++;
    if (pay_q.size() !== 92) begin $display("FAIL b2b_pay_len got %0d want 92", pay_q.size()); fails++; end vecs++;
    if ({crc_err, prmbl_err, len_err, end_err} !== 4'b0000) begin
      $display("FAIL b2b_flags got %b want 0000", {crc_err, prmbl_err, len_err, end_err}); fails++; end vecs++;
  endtask

  task automatic test_reset_mid_frame();
    build(16'h0800, 46);
    clear_mon();
    send(7, -1, 30, 1'b1);
    idle(3);
    if (rcvd_cnt !== 0) begin $display("FAIL midrst_rcvd got %0d want 0", rcvd_cnt); fails++; end vecs++;
    if ({dst, src, frmtype, byte_cnt} !== 128'd0) begin $display("FAIL midrst_fields got %h want 0", {dst, src, frmtype, byte_cnt}); fails++; end vecs++;
    if ({prmble_len, payload, crc_err, prmbl_err, len_err, frame_err, end_err} !== 27'd0) begin
      $display("FAIL midrst_status got %h want 0", {prmble_len, payload, crc_err, prmbl_err, len_err, frame_err, end_err}); fails++; end vecs++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_err();
    test_short_preamble();
    test_sfd_only_min_len();
    test_truncated();
    test_tx_er();
    test_lengths();
    test_back_to_back();
    test_reset_mid_frame();
    test_good_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
